// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Pure declarations: no latency, no backpressure.
// Optional error counter is enabled with TDM_DEMUX_ERRCNT_EN.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Slot index width; never narrower than one bit.
    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: load-to-1 on sync, increment per word, wrap after the last slot.
// Latency: sel updates on the edge after load1/inc; last is combinational from sel.
// No backpressure: advances only when told to.
module tdm_slot_counter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load1,
    input  logic             inc,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    assign last = (sel == SEL_W'(CHANNELS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
        end else if (load1) begin
            sel <= SEL_W'(1);
        end else if (inc) begin
            sel <= last ? '0 : sel + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Word-serial TDM receiver: aligns on frame_sync and publishes whole frames in parallel.
// Latency: out_data/out_valid register on the edge that accepts the last slot word.
// No backpressure: every qualified word is consumed; optional err_count via TDM_DEMUX_ERRCNT_EN.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 8,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          sel,
    output logic                      locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic [7:0]                err_count,
`endif
    output logic                      frame_err
);

    state_t                    state, state_n;
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic                      last;
    logic                      wr_zero, wr_en, load1, inc, publish, err;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .load1 (load1),
        .inc   (inc),
        .sel   (sel),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        wr_zero = 1'b0;
        wr_en   = 1'b0;
        load1   = 1'b0;
        inc     = 1'b0;
        publish = 1'b0;
        err     = 1'b0;
        case (state)
            HUNT: begin
                if (in_valid && frame_sync) begin
                    wr_zero = 1'b1;
                    load1   = 1'b1;
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    if (frame_sync) begin
                        // Sync mid-frame restarts alignment on this word.
                        wr_zero = 1'b1;
                        load1   = 1'b1;
                        err     = (sel != '0);
                    end else if (sel == '0) begin
                        err     = 1'b1;
                        state_n = HUNT;
                    end else begin
                        wr_en   = 1'b1;
                        inc     = 1'b1;
                        publish = last;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= publish;
            frame_err <= err;
            if (wr_zero) begin
                shadow[WIDTH-1:0] <= in_data;
            end else if (wr_en) begin
                shadow[int'(sel)*WIDTH +: WIDTH] <= in_data;
            end
            // The final word bypasses the shadow so the frame lands in one edge.
            if (publish) begin
                out_data <= {in_data, shadow[(CHANNELS-1)*WIDTH-1:0]};
            end
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CHANNELS=4, WIDTH=8): vector table plus reset/counter sequences.
module tb_tdm_demux;
    import tdm_demux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  sel;
    logic        locked;
    logic        frame_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .sel        (sel),
        .locked     (locked),
`ifdef TDM_DEMUX_ERRCNT_EN
        .err_count  (err_count),
`endif
        .frame_err  (frame_err)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic        ov;
        logic [31:0] od;
        logic        lk;
        logic        fe;
        logic [1:0]  sl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic s, input logic [7:0] d, input logic ov,
                       input logic [31:0] od, input logic lk, input logic fe, input logic [1:0] sl);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.ov = ov; t.od = od; t.lk = lk; t.fe = fe; t.sl = sl;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid   = v;
        frame_sync = s;
        in_data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [31:0] od,
                           input logic lk, input logic fe, input logic [1:0] sl);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " out_data"},  out_data,       od);
        chk({tag, " locked"},    32'(locked),    32'(lk));
        chk({tag, " frame_err"}, 32'(frame_err), 32'(fe));
        chk({tag, " sel"},       32'(sel),       32'(sl));
    endtask

    initial begin
        // Words before first sync are ignored.
        add(1, 0, 8'hAA, 0, 32'h0,        0, 0, 0);
        add(1, 0, 8'hBB, 0, 32'h0,        0, 0, 0);
        add(1, 1, 8'h11, 0, 32'h0,        1, 0, 1);
        add(1, 0, 8'h22, 0, 32'h0,        1, 0, 2);
        add(1, 0, 8'h33, 0, 32'h0,        1, 0, 3);
        add(1, 0, 8'h44, 1, 32'h44332211, 1, 0, 0);
        add(0, 0, 8'h00, 0, 32'h44332211, 1, 0, 0);
        // frame_sync without in_valid is ignored; next frame back to back.
        add(0, 1, 8'h99, 0, 32'h44332211, 1, 0, 0);
        add(1, 1, 8'h55, 0, 32'h44332211, 1, 0, 1);
        add(1, 0, 8'h66, 0, 32'h44332211, 1, 0, 2);
        add(1, 0, 8'h77, 0, 32'h44332211, 1, 0, 3);
        add(1, 0, 8'h88, 1, 32'h88776655, 1, 0, 0);
        // Frame with 3-cycle gaps between words.
        add(1, 1, 8'h11, 0, 32'h88776655, 1, 0, 1);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 1);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 1);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 1);
        add(1, 0, 8'h22, 0, 32'h88776655, 1, 0, 2);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 2);
        add(0, 1, 8'hFF, 0, 32'h88776655, 1, 0, 2);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 2);
        add(1, 0, 8'h33, 0, 32'h88776655, 1, 0, 3);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 3);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 3);
        add(0, 0, 8'hFF, 0, 32'h88776655, 1, 0, 3);
        add(1, 0, 8'h44, 1, 32'h44332211, 1, 0, 0);
        add(0, 0, 8'h00, 0, 32'h44332211, 1, 0, 0);
        // Sync on 2nd word: error, resync, new frame completes.
        add(1, 1, 8'hA1, 0, 32'h44332211, 1, 0, 1);
        add(1, 1, 8'hB1, 0, 32'h44332211, 1, 1, 1);
        add(1, 0, 8'hB2, 0, 32'h44332211, 1, 0, 2);
        add(1, 0, 8'hB3, 0, 32'h44332211, 1, 0, 3);
        add(1, 0, 8'hB4, 1, 32'hB4B3B2B1, 1, 0, 0);
        // Slot-0 word without sync: error, back to hunt, out_data kept.
        add(1, 0, 8'hC0, 0, 32'hB4B3B2B1, 0, 1, 0);
        add(1, 0, 8'hC1, 0, 32'hB4B3B2B1, 0, 0, 0);
        add(1, 1, 8'hD1, 0, 32'hB4B3B2B1, 1, 0, 1);
        add(1, 0, 8'hD2, 0, 32'hB4B3B2B1, 1, 0, 2);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].od, vecs[i].lk, vecs[i].fe, vecs[i].sl);
        end

`ifdef TDM_DEMUX_ERRCNT_EN
        chk("err_count after table", 32'(err_count), 32'd2);
`endif

        // Reset mid-frame (two words in): outputs clear without waiting for a clock.
        @(negedge clk);
        in_valid = 1'b0;
        frame_sync = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("midrst", 0, 32'h0, 0, 0, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("midrst err_count", 32'(err_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        // Remainder of the discarded frame must be ignored in HUNT.
        drive(1, 0, 8'hD3);
        chk_all("postrst D3", 0, 32'h0, 0, 0, 0);
        drive(1, 0, 8'hD4);
        chk_all("postrst D4", 0, 32'h0, 0, 0, 0);

`ifdef TDM_DEMUX_ERRCNT_EN
        drive(1, 1, 8'h01);
        for (int k = 0; k < 300; k++) begin
            drive(1, 1, 8'h02);
        end
        drive(0, 0, 8'h00);
        chk("err_count saturate", 32'(err_count), 32'd255);
        chk("saturate locked", 32'(locked), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
